// File: rtl/hdlc_tx_arbiter.sv
// rtl/hdlc_tx_arbiter.sv - round-robin arbiter sharing the HDLC Tx buffer/controller among N_REQ byte streams
// Optional WAIT_TX watchdog: define HDLC_TXARB_WDOG_EN.
module hdlc_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MAX_BYTES   = 126,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [N_REQ-1:0]     Req_Valid,
  input  logic [8*N_REQ-1:0]   Req_Data,
  input  logic [N_REQ-1:0]     Req_Last,
  input  logic [N_REQ-1:0]     Req_Abort,
  output logic [N_REQ-1:0]     Req_Ready,
  output logic [N_REQ-1:0]     Grant,
  output logic [N_REQ-1:0]     Done,
  output logic [N_REQ-1:0]     Aborted,
  input  logic                 Tx_Done,
  input  logic                 Tx_Full,
  input  logic                 Tx_ValidFrame,
  output logic                 Tx_WrBuff,
  output logic [7:0]           Tx_DataIn,
  output logic                 Tx_Enable,
  output logic                 Tx_AbortFrame,
  output logic                 Wdog_Err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_TX, ABORT} stateT;

  stateT            state, stateNext;
  logic [IW-1:0]    ptr, ptrNext;
  logic [CW-1:0]    cnt, cntNext;
  logic             startWait, startWaitNext;
  logic             sawValid, sawValidNext;
  logic             wrBuff, wrBuffNext;
  logic [7:0]       dataIn, dataInNext;
  logic             txEnable, txEnableNext;
  logic             txAbort, txAbortNext;
  logic [N_REQ-1:0] doneQ, doneNext;
  logic [N_REQ-1:0] abortedQ, abortedNext;
  logic [N_REQ-1:0] grantVec, readyVec;
  logic [IW-1:0]    pickIdx, candIdx;
  logic             pickFound;
  logic             loadReady, hs, reqAbort;

`ifdef HDLC_TXARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdogCnt, wdogCntNext;
  logic          wdogHit, wdogHitNext;
  logic          wdogErrQ, wdogErrNext;
  logic          wdogExpired;
  assign wdogExpired = (wdogCnt == WW'(WDOG_CYCLES - 1));
  assign Wdog_Err    = wdogErrQ;
`else
  logic unusedWdogCfg;
  assign unusedWdogCfg = (WDOG_CYCLES > 0);
  assign Wdog_Err      = 1'b0;
`endif

  // ptr holds the granted index while busy, and the last winner while idle
  assign loadReady = (state == LOAD) && !Tx_Full && (cnt < CW'(MAX_BYTES));
  assign hs        = Req_Valid[ptr] && loadReady;
  assign reqAbort  = Req_Abort[ptr];

  // One-hot grant and ready vectors derived from the granted index
  always_comb begin
    grantVec = '0;
    readyVec = '0;
    if (state != IDLE) grantVec[ptr] = 1'b1;
    readyVec[ptr] = loadReady;
  end

  // Round-robin search: first valid requester strictly after the pointer
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    candIdx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      candIdx = IW'((int'(ptr) + k) % N_REQ);
      if (!pickFound && Req_Valid[candIdx]) begin
        pickFound = 1'b1;
        pickIdx   = candIdx;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    stateNext     = state;
    ptrNext       = ptr;
    cntNext       = cnt;
    startWaitNext = 1'b0;
    sawValidNext  = sawValid;
    wrBuffNext    = 1'b0;
    dataInNext    = dataIn;
    txEnableNext  = 1'b0;
    txAbortNext   = 1'b0;
    doneNext      = '0;
    abortedNext   = '0;
`ifdef HDLC_TXARB_WDOG_EN
    wdogCntNext   = wdogCnt;
    wdogHitNext   = wdogHit;
    wdogErrNext   = 1'b0;
`endif
    case (state)
      IDLE: begin
        cntNext = '0;
        if (Tx_Done && pickFound) begin
          stateNext = LOAD;
          ptrNext   = pickIdx;
        end
      end
      LOAD: begin
        // abort wins over a same-cycle handshake, so that byte is dropped
        if (reqAbort) begin
          stateNext   = ABORT;
          txAbortNext = 1'b1;
        end else if (hs) begin
          wrBuffNext = 1'b1;
          dataInNext = Req_Data[{ptr, 3'b000} +: 8];
          cntNext    = cnt + CW'(1);
          if (Req_Last[ptr]) stateNext = START;
        end else if (cnt == CW'(MAX_BYTES)) begin
          stateNext   = ABORT;
          txAbortNext = 1'b1;
        end
      end
      START: begin
        // first cycle lets the final buffer write land before enabling Tx
        if (!startWait) begin
          startWaitNext = 1'b1;
        end else begin
          txEnableNext = 1'b1;
          sawValidNext = 1'b0;
          stateNext    = WAIT_TX;
`ifdef HDLC_TXARB_WDOG_EN
          wdogCntNext  = '0;
`endif
        end
      end
      WAIT_TX: begin
        if (reqAbort) begin
          stateNext   = ABORT;
          txAbortNext = 1'b1;
        end
`ifdef HDLC_TXARB_WDOG_EN
        else if (wdogExpired) begin
          stateNext   = ABORT;
          txAbortNext = 1'b1;
          wdogHitNext = 1'b1;
        end
`endif
        else if (sawValid && !Tx_ValidFrame) begin
          doneNext  = grantVec;
          stateNext = IDLE;
        end else begin
          if (Tx_ValidFrame) sawValidNext = 1'b1;
`ifdef HDLC_TXARB_WDOG_EN
          wdogCntNext = wdogCnt + WW'(1);
`endif
        end
      end
      ABORT: begin
        // txAbort high marks the pulse cycle; settle check starts after it
        if (!txAbort && !Tx_ValidFrame && Tx_Done) begin
          abortedNext = grantVec;
          stateNext   = IDLE;
`ifdef HDLC_TXARB_WDOG_EN
          wdogErrNext = wdogHit;
          wdogHitNext = 1'b0;
`endif
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      ptr       <= IW'(N_REQ - 1);
      cnt       <= '0;
      startWait <= 1'b0;
      sawValid  <= 1'b0;
      wrBuff    <= 1'b0;
      dataIn    <= '0;
      txEnable  <= 1'b0;
      txAbort   <= 1'b0;
      doneQ     <= '0;
      abortedQ  <= '0;
    end else begin
      state     <= stateNext;
      ptr       <= ptrNext;
      cnt       <= cntNext;
      startWait <= startWaitNext;
      sawValid  <= sawValidNext;
      wrBuff    <= wrBuffNext;
      dataIn    <= dataInNext;
      txEnable  <= txEnableNext;
      txAbort   <= txAbortNext;
      doneQ     <= doneNext;
      abortedQ  <= abortedNext;
    end
  end

`ifdef HDLC_TXARB_WDOG_EN
  // Watchdog counter and cause flag
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wdogCnt  <= '0;
      wdogHit  <= 1'b0;
      wdogErrQ <= 1'b0;
    end else begin
      wdogCnt  <= wdogCntNext;
      wdogHit  <= wdogHitNext;
      wdogErrQ <= wdogErrNext;
    end
  end
`endif

  assign Req_Ready     = readyVec;
  assign Grant         = grantVec;
  assign Done          = doneQ;
  assign Aborted       = abortedQ;
  assign Tx_WrBuff     = wrBuff;
  assign Tx_DataIn     = dataIn;
  assign Tx_Enable     = txEnable;
  assign Tx_AbortFrame = txAbort;

endmodule

// File: tb/tb_hdlc_tx_arbiter.sv
// tb/tb_hdlc_tx_arbiter.sv - directed self-checking bench for hdlc_tx_arbiter
module tb_hdlc_tx_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [3:0]  Req_Valid, Req_Last, Req_Abort;
  logic [31:0] Req_Data;
  logic [3:0]  Req_Ready, Grant, Done, Aborted;
  logic        Tx_Done, Tx_Full, Tx_ValidFrame;
  logic        Tx_WrBuff, Tx_Enable, Tx_AbortFrame, Wdog_Err;
  logic [7:0]  Tx_DataIn;

  int total = 0;
  int bad   = 0;
  int writes, enables;
  logic expAb;

  hdlc_tx_arbiter #(.N_REQ(4), .MAX_BYTES(126), .WDOG_CYCLES(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req_Valid(Req_Valid), .Req_Data(Req_Data), .Req_Last(Req_Last), .Req_Abort(Req_Abort),
    .Req_Ready(Req_Ready), .Grant(Grant), .Done(Done), .Aborted(Aborted),
    .Tx_Done(Tx_Done), .Tx_Full(Tx_Full), .Tx_ValidFrame(Tx_ValidFrame),
    .Tx_WrBuff(Tx_WrBuff), .Tx_DataIn(Tx_DataIn), .Tx_Enable(Tx_Enable),
    .Tx_AbortFrame(Tx_AbortFrame), .Wdog_Err(Wdog_Err)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Single-byte frame from requester g, starting in IDLE
  task automatic oneByteFrame(input int g, input logic [7:0] d);
    Req_Data[8*g +: 8] = d;
    Req_Last[g]  = 1'b1;
    Req_Valid[g] = 1'b1;
    step();
    chk($sformatf("f%0d_grant", g), {28'd0, Grant}, 32'(1 << g));
    chk($sformatf("f%0d_onehot", g), {31'd0, $onehot0(Grant)}, 32'd1);
    step();
    Req_Valid[g] = 1'b0;
    Req_Last[g]  = 1'b0;
    chk($sformatf("f%0d_wr", g), {23'd0, Tx_WrBuff, Tx_DataIn}, {23'd0, 1'b1, d});
    step();
    chk($sformatf("f%0d_en_lo", g), {31'd0, Tx_Enable}, 32'd0);
    step();
    chk($sformatf("f%0d_en_hi", g), {31'd0, Tx_Enable}, 32'd1);
    Tx_ValidFrame = 1'b1;
    step();
    Tx_ValidFrame = 1'b0;
    step();
    chk($sformatf("f%0d_done", g), {28'd0, Done}, 32'(1 << g));
    chk($sformatf("f%0d_grant_clr", g), {28'd0, Grant}, 32'd0);
  endtask

  initial begin
    Rst = 1'b1; Req_Valid = '0; Req_Last = '0; Req_Abort = '0; Req_Data = '0;
    Tx_Done = 1'b1; Tx_Full = 1'b0; Tx_ValidFrame = 1'b0;
    step(); step();
    chk("rst_grant", {28'd0, Grant}, 32'd0);
    chk("rst_ready", {28'd0, Req_Ready}, 32'd0);
    chk("rst_outs", {26'd0, Tx_WrBuff, Tx_Enable, Tx_AbortFrame, Wdog_Err, |Done, |Aborted}, 32'd0);

    // Test 1: three-byte frame from requester 0
    Rst = 1'b0;
    Req_Valid = 4'b0001; Req_Data[7:0] = 8'h11;
    step();
    chk("t1_grant", {28'd0, Grant}, 32'h1);
    chk("t1_ready", {28'd0, Req_Ready}, 32'h1);
    step();
    chk("t1_wr11", {23'd0, Tx_WrBuff, Tx_DataIn}, {23'd0, 9'h111});
    Req_Data[7:0] = 8'h22;
    step();
    chk("t1_wr22", {23'd0, Tx_WrBuff, Tx_DataIn}, {23'd0, 9'h122});
    Req_Data[7:0] = 8'h33; Req_Last[0] = 1'b1;
    step();
    chk("t1_wr33", {23'd0, Tx_WrBuff, Tx_DataIn}, {23'd0, 9'h133});
    chk("t1_en0", {31'd0, Tx_Enable}, 32'd0);
    Req_Valid = '0; Req_Last = '0;
    step();
    chk("t1_en1", {30'd0, Tx_Enable, Tx_WrBuff}, 32'd0);
    step();
    chk("t1_en2", {31'd0, Tx_Enable}, 32'd1);
    Tx_Done = 1'b0; Tx_ValidFrame = 1'b1;
    step();
    chk("t1_en_pulse", {31'd0, Tx_Enable}, 32'd0);
    step();
    chk("t1_no_done", {28'd0, Done}, 32'd0);
    Tx_ValidFrame = 1'b0; Tx_Done = 1'b1;
    step();
    chk("t1_done", {28'd0, Done}, 32'h1);
    chk("t1_grant_clr", {28'd0, Grant}, 32'd0);
    step();
    chk("t1_done_pulse", {28'd0, Done}, 32'd0);

    // Test 2: all four request together after reset, then 0 re-requests
    Rst = 1'b1; step(); Rst = 1'b0;
    Req_Valid = 4'b1111; Req_Last = 4'b1111;
    for (int g = 0; g < 4; g++) oneByteFrame(g, 8'(8'hA0 + g));
    oneByteFrame(0, 8'hB0);

    // Test 3: requester 1 overflows the buffer without Last
    Req_Valid = 4'b0010;
    step();
    chk("t3_grant", {28'd0, Grant}, 32'h2);
    Tx_Full = 1'b1;
    #1;
    chk("t3_ready_full", {28'd0, Req_Ready}, 32'd0);
    step();
    chk("t3_wr_full", {31'd0, Tx_WrBuff}, 32'd0);
    Tx_Full = 1'b0;
    writes = 0; enables = 0;
    for (int i = 0; i < 126; i++) begin
      Req_Data[15:8] = 8'(i + 3);
      step();
      if (Tx_WrBuff && Tx_DataIn == 8'(i + 3)) writes++;
      enables += int'(Tx_Enable);
    end
    chk("t3_ready_drop", {28'd0, Req_Ready}, 32'd0);
    chk("t3_writes", 32'(writes), 32'd126);
    Req_Valid = '0;
    step();
    chk("t3_abortframe", {30'd0, Tx_AbortFrame, Tx_WrBuff}, 32'h2);
    step();
    chk("t3_abort_pulse", {27'd0, Tx_AbortFrame, Aborted}, 32'd0);
    step();
    chk("t3_aborted", {28'd0, Aborted}, 32'h2);
    chk("t3_grant_clr", {28'd0, Grant}, 32'd0);
    chk("t3_no_enable", 32'(enables) + {31'd0, Tx_Enable}, 32'd0);

    // Test 4: requester 2 aborts during transmission
    Req_Valid = 4'b0100; Req_Last = 4'b0100; Req_Data[23:16] = 8'h44;
    step();
    chk("t4_grant", {28'd0, Grant}, 32'h4);
    step();
    chk("t4_wr", {23'd0, Tx_WrBuff, Tx_DataIn}, {23'd0, 9'h144});
    Req_Valid = '0; Req_Last = '0;
    step(); step();
    chk("t4_en", {31'd0, Tx_Enable}, 32'd1);
    Tx_ValidFrame = 1'b1; Tx_Done = 1'b0;
    step();
    Req_Abort = 4'b0001;
    step();
    chk("t4_foreign_abort", {31'd0, Tx_AbortFrame}, 32'd0);
    Req_Abort = 4'b0100;
    step();
    chk("t4_abortframe", {27'd0, Tx_AbortFrame, Grant}, 32'h14);
    Req_Abort = '0;
    step();
    chk("t4_wait_vf", {27'd0, Tx_AbortFrame, Aborted}, 32'd0);
    Tx_ValidFrame = 1'b0;
    step();
    chk("t4_wait_txdone", {28'd0, Aborted}, 32'd0);
    Tx_Done = 1'b1;
    step();
    chk("t4_aborted", {24'd0, Done, Aborted}, 32'h04);
    chk("t4_grant_clr", {28'd0, Grant}, 32'd0);

    // Abort in LOAD beats a same-cycle Last handshake (requester 3)
    Req_Valid = 4'b1000; Req_Data[31:24] = 8'h55;
    step();
    chk("t4b_grant", {28'd0, Grant}, 32'h8);
    Req_Last = 4'b1000; Req_Abort = 4'b1000;
    step();
    chk("t4b_nowrite", {30'd0, Tx_AbortFrame, Tx_WrBuff}, 32'h2);
    Req_Valid = '0; Req_Last = '0; Req_Abort = '0;
    step();
    chk("t4b_hold", {28'd0, Aborted}, 32'd0);
    step();
    chk("t4b_aborted", {28'd0, Aborted}, 32'h8);

    // Test 5: no grant while Tx_Done is low
    Tx_Done = 1'b0;
    Req_Valid = 4'b0001; Req_Last = 4'b0001; Req_Data[7:0] = 8'h66;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t5_nogrant%0d", k), {28'd0, Grant}, 32'd0);
    end
    Tx_Done = 1'b1;
    step();
    chk("t5_grant", {28'd0, Grant}, 32'h1);
    step();
    chk("t5_wr", {23'd0, Tx_WrBuff, Tx_DataIn}, {23'd0, 9'h166});
    Req_Valid = '0; Req_Last = '0;
    step(); step();
    chk("t5_en", {31'd0, Tx_Enable}, 32'd1);

    // Test 6: Tx_ValidFrame stuck high in WAIT_TX
    Tx_ValidFrame = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
`ifdef HDLC_TXARB_WDOG_EN
      expAb = (k == 16);
`else
      expAb = 1'b0;
`endif
      chk($sformatf("t6_abort_c%0d", k), {31'd0, Tx_AbortFrame}, {31'd0, expAb});
    end
`ifdef HDLC_TXARB_WDOG_EN
    Tx_ValidFrame = 1'b0;
    step();
    chk("t6_wdog_early", {31'd0, Wdog_Err}, 32'd0);
    step();
    chk("t6_wdog", {27'd0, Wdog_Err, Aborted}, 32'h11);
`else
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t6_still_wait%0d", k), {27'd0, Tx_AbortFrame, Done}, 32'd0);
    end
    Tx_ValidFrame = 1'b0;
    step();
    chk("t6_done", {27'd0, Wdog_Err, Done}, 32'h01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
